// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the FIFO read-side drain engine.
// Defaults match the team's sync FIFO instances.
package fifo_rd_pkg;

    localparam int unsigned FIFO_DW     = 18;
    localparam int unsigned FIFO_RD_LAT = 2;

    // Ceiling log2 for sizing counters at elaboration time.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rd_credit_buf.sv
// Circular register buffer that absorbs FIFO read data ahead of the stream port.
// It drops a push only when it is full and nothing pops in the same cycle.
module rd_credit_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DW      = FIFO_DW,
    parameter int unsigned BUF_PTR = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DW-1:0]    din,
    input  logic             pop,
    output logic [DW-1:0]    dout,
    output logic [BUF_PTR:0] cnt,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned DEPTH = 1 << BUF_PTR;

    logic [DW-1:0]      mem [DEPTH];
    logic [BUF_PTR-1:0] wr_ptr;
    logic [BUF_PTR-1:0] rd_ptr;
    logic               wr_en_c;
    logic               rd_en_c;

    assign full_c  = (cnt == (BUF_PTR+1)'(DEPTH));
    assign empty_c = (cnt == '0);
    assign rd_en_c = pop & ~empty_c;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign wr_en_c = push & (~full_c | rd_en_c);
    assign dout    = mem[rd_ptr];

    // Pointer and count bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + BUF_PTR'(1);
            end
            if (rd_en_c) begin
                rd_ptr <= rd_ptr + BUF_PTR'(1);
            end
            case ({wr_en_c, rd_en_c})
                2'b10:   cnt <= cnt + (BUF_PTR+1)'(1);
                2'b01:   cnt <= cnt - (BUF_PTR+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; unwritten slots are never presented as valid.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: strobes a fixed-latency FIFO only when every in-flight
// word has a guaranteed buffer slot, then presents the words on a valid/ready stream.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DW      = FIFO_DW,
    parameter int unsigned RD_LAT  = FIFO_RD_LAT,
    parameter int unsigned BUF_PTR = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_ren,
    input  logic             fifo_dout_valid,
    input  logic [DW-1:0]    fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [BUF_PTR:0] occupancy,
    output logic             ovf_err
);

    localparam int unsigned BUF_DEPTH = 1 << BUF_PTR;
    localparam int unsigned IF_W      = clog2_f(RD_LAT + 1);
    localparam int unsigned SUM_W     = BUF_PTR + 2;

    if (BUF_DEPTH < RD_LAT + 1) begin : g_bad_depth
        $error("fifo_rd_stream: BUF_DEPTH must be at least RD_LAT+1");
    end
    if (RD_LAT < 1) begin : g_bad_lat
        $error("fifo_rd_stream: RD_LAT must be at least 1");
    end

    logic [IF_W-1:0]  inflight;
    logic [BUF_PTR:0] buf_cnt;
    logic             buf_full_c;
    logic             buf_empty_c;
    logic             pop_c;
    logic             credit_ok_c;

    rd_credit_buf #(
        .DW      (DW),
        .BUF_PTR (BUF_PTR)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_dout_valid),
        .din     (fifo_dout),
        .pop     (pop_c),
        .dout    (m_data),
        .cnt     (buf_cnt),
        .full_c  (buf_full_c),
        .empty_c (buf_empty_c)
    );

    assign m_valid   = ~buf_empty_c;
    assign occupancy = buf_cnt;
    assign pop_c     = m_valid & m_ready;

    // Widened sum so a full buffer plus in-flight words cannot wrap past the limit.
    assign credit_ok_c = (SUM_W'(buf_cnt) + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH);
    assign fifo_ren    = rst_n & enable & ~fifo_empty & credit_ok_c;

    // Words strobed but not yet returned; a stray return never wraps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (fifo_ren && !fifo_dout_valid) begin
            inflight <= inflight + IF_W'(1);
        end else if (!fifo_ren && fifo_dout_valid && (inflight != '0)) begin
            inflight <= inflight - IF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (fifo_dout_valid && buf_full_c && !pop_c) begin
            ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural 2-cycle FIFO, occupancy/credit model and
// a delivery-order scoreboard, driven by a scenario table plus hand-built sequences.
module tb_fifo_rd_stream;

    localparam int unsigned DW    = 18;
    localparam int          DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_ren;
    logic          fifo_dout_valid;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [2:0]    occupancy;
    logic          ovf_err;

    fifo_rd_stream #(.DW(DW), .RD_LAT(2), .BUF_PTR(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .fifo_empty      (fifo_empty),
        .fifo_ren        (fifo_ren),
        .fifo_dout_valid (fifo_dout_valid),
        .fifo_dout       (fifo_dout),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .occupancy       (occupancy),
        .ovf_err         (ovf_err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: word leaves the queue on ren and returns two cycles later.
    logic [DW-1:0] fq[$];
    logic          p1_v = 1'b0, p2_v = 1'b0, inj_v = 1'b0, stall_en = 1'b0;
    logic [DW-1:0] p1_d = '0, p2_d = '0, inj_d = '0, fq_w;

    assign fifo_dout_valid = p2_v | inj_v;
    assign fifo_dout       = inj_v ? inj_d : p2_d;

    always @(posedge clk) begin
        if (!rst_n) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
        end else begin
            p2_v <= p1_v;
            p2_d <= p1_d;
            p1_v <= fifo_ren;
            if (fifo_ren && fq.size() > 0) begin
                fq_w = fq.pop_front();
                p1_d <= fq_w;
            end
        end
        fifo_empty <= (fq.size() == 0) || (stall_en && ($urandom_range(0, 1) == 1));
    end

    int            errors = 0, checks = 0, cyc = 0;
    int            mdl_cnt, ren_cnt, beats, first_ren, first_mv, last_beat;
    logic          exp_ovf;
    logic [DW-1:0] exp_order[$];

    typedef struct {
        int            n;
        logic [DW-1:0] base;
        int            hold;
        int            exp_ren;
        int            exp_occ;
        logic [DW-1:0] exp_head;
    } scen_t;
    scen_t tbl[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", nm, cyc, act, exp);
        end
    endtask

    // One cycle: drive at the negedge, check settled outputs, advance the model.
    task automatic tick(input logic rdy, input logic en);
        int   outst;
        logic pop;
        logic exp_ren;
        m_ready = rdy;
        enable  = en;
        #1;
        outst   = int'(p1_v) + int'(p2_v);
        exp_ren = en && !fifo_empty && (mdl_cnt + outst < DEPTH);
        pop     = (mdl_cnt != 0) && rdy;
        check("fifo_ren", 32'(fifo_ren), 32'(exp_ren));
        check("occupancy", 32'(occupancy), 32'(mdl_cnt));
        check("m_valid", 32'(m_valid), 32'(mdl_cnt != 0));
        check("ovf_err", 32'(ovf_err), 32'(exp_ovf));
        check("credit", 32'((int'(occupancy) + outst) <= DEPTH), 32'd1);
        if (mdl_cnt != 0 && exp_order.size() != 0) begin
            check("m_data", 32'(m_data), 32'(exp_order[0]));
        end
        if (fifo_ren) begin
            ren_cnt++;
            if (first_ren < 0) first_ren = cyc;
        end
        if (mdl_cnt != 0 && first_mv < 0) first_mv = cyc;
        if (pop) begin
            beats++;
            last_beat = cyc;
            if (exp_order.size() != 0) void'(exp_order.pop_front());
        end
        if (fifo_dout_valid && !(mdl_cnt == DEPTH && !pop)) mdl_cnt++;
        if (pop) mdl_cnt--;
        cyc++;
        @(negedge clk);
    endtask

    // Reset with the FIFO preloaded, check reset values, release at a negedge.
    task automatic start(input int n, input logic [DW-1:0] base, input logic rnd);
        logic [DW-1:0] w;
        rst_n   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b0;
        inj_v   = 1'b0;
        fq.delete();
        exp_order.delete();
        for (int i = 0; i < n; i++) begin
            w = rnd ? DW'($urandom) : base + DW'(i);
            fq.push_back(w);
            exp_order.push_back(w);
        end
        repeat (2) @(negedge clk);
        #1;
        check("rst_fifo_ren", 32'(fifo_ren), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
        @(negedge clk);
        mdl_cnt = 0; ren_cnt = 0; beats = 0;
        first_ren = -1; first_mv = -1; last_beat = -1;
        cyc = 0; exp_ovf = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{16, 18'h00001, 0,  0, 0, 18'h00000};
        tbl[1] = '{16, 18'h00001, 12, 4, 4, 18'h00001};
        tbl[2] = '{3,  18'h00100, 10, 3, 3, 18'h00100};
        tbl[3] = '{1,  18'h2AAAA, 0,  0, 0, 18'h00000};

        @(negedge clk);

        for (int s = 0; s < 4; s++) begin
            start(tbl[s].n, tbl[s].base, 1'b0);
            if (tbl[s].hold > 0) begin
                for (int i = 0; i < tbl[s].hold; i++) tick(1'b0, 1'b1);
                check("bp_ren_pulses", 32'(ren_cnt), 32'(tbl[s].exp_ren));
                check("bp_occupancy", 32'(occupancy), 32'(tbl[s].exp_occ));
                check("bp_head", 32'(m_data), 32'(tbl[s].exp_head));
            end
            for (int i = 0; i < 200 && beats < tbl[s].n; i++) tick(1'b1, 1'b1);
            check("beats", 32'(beats), 32'(tbl[s].n));
            if (tbl[s].hold == 0) begin
                check("first_ren_cycle", 32'(first_ren), 32'd0);
                check("latency", 32'(first_mv - first_ren), 32'd3);
                check("no_gaps", 32'(last_beat - first_mv), 32'(tbl[s].n - 1));
            end
        end

        // Alternating ready with a randomly stalling FIFO.
        stall_en = 1'b1;
        start(24, '0, 1'b1);
        for (int i = 0; i < 600 && beats < 24; i++) tick(1'((cyc % 2) == 0), 1'b1);
        check("alt_beats", 32'(beats), 32'd24);
        stall_en = 1'b0;

        // Enable drops after two strobes.
        start(16, 18'h00200, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
        check("en_ren_pulses", 32'(ren_cnt), 32'd2);
        check("en_beats", 32'(beats), 32'd2);

        // Forced overflow, then reset mid-stream.
        start(16, 18'h00001, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
        check("ovf_pre_occ", 32'(occupancy), 32'd4);
        inj_d   = 18'h3FFFF;
        inj_v   = 1'b1;
        m_ready = 1'b0;
        #1;
        check("ovf_inj_ren", 32'(fifo_ren), 32'd0);
        @(negedge clk);
        inj_v   = 1'b0;
        exp_ovf = 1'b1;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("ovf_sticky_occ", 32'(occupancy), 32'd4);
        check("ovf_head", 32'(m_data), 32'h00001);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        check("ovf_drain_beats", 32'(beats), 32'd6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ovf", 32'(ovf_err), 32'd0);
        check("mid_rst_occ", 32'(occupancy), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_ren", 32'(fifo_ren), 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
